// File: rtl/matrix_fmt_pkg.sv
// Shared constants and state encoding for the matrix ASCII formatter.
package matrix_fmt_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_LF    = 8'd10;
    localparam logic [7:0] ASCII_CR    = 8'd13;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CONV,
        S_EMIT_DIG,
        S_EMIT_SEP,
        S_EMIT_CR,
        S_EMIT_LF,
        S_DONE
    } fmt_state_e;

    function automatic logic is_emit(input fmt_state_e s);
        return s inside {S_EMIT_DIG, S_EMIT_SEP, S_EMIT_CR, S_EMIT_LF};
    endfunction

endpackage

// File: rtl/matrix_ascii_formatter_bin2dec.sv
// Sequential binary to 3-digit BCD converter, one subtraction per cycle.
module bin2dec_digits #(
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ELEM_W-1:0] value,
    output logic              done,
    output logic [3:0]        dig_h,
    output logic [3:0]        dig_t,
    output logic [3:0]        dig_o,
    output logic [1:0]        ndig
);

    localparam logic [ELEM_W-1:0] HUNDRED = ELEM_W'(100);
    localparam logic [ELEM_W-1:0] TEN     = ELEM_W'(10);

    logic              running;
    logic              phase_tens;
    logic [ELEM_W-1:0] rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running    <= 1'b0;
            phase_tens <= 1'b0;
            rem        <= '0;
            dig_h      <= '0;
            dig_t      <= '0;
            dig_o      <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running    <= 1'b1;
                phase_tens <= 1'b0;
                rem        <= value;
                dig_h      <= '0;
                dig_t      <= '0;
            end else if (running) begin
                if (!phase_tens) begin
                    if (rem >= HUNDRED) begin
                        rem   <= rem - HUNDRED;
                        dig_h <= dig_h + 4'd1;
                    end else begin
                        phase_tens <= 1'b1;
                    end
                end else if (rem >= TEN) begin
                    rem   <= rem - TEN;
                    dig_t <= dig_t + 4'd1;
                end else begin
                    dig_o   <= rem[3:0];
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // A zero value still reports one significant digit.
    assign ndig = (dig_h != 4'd0) ? 2'd3 : (dig_t != 4'd0) ? 2'd2 : 2'd1;

endmodule

// File: rtl/matrix_ascii_formatter.sv
// Streams an R x C matrix as decimal ASCII rows over a valid/ready byte interface.
module matrix_ascii_formatter
    import matrix_fmt_pkg::*;
#(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int ADDR_W  = 5,
    parameter int CRLF    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [ELEM_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              new_line,
    output logic              busy,
    output logic              done
);

    fmt_state_e       state_q, state_nx;
    logic [DIM_W-1:0] rows_q, cols_q, r_q, c_q;
    logic [1:0]       dig_idx_q, dig_idx_nx;
    logic             conv_start, conv_done;
    logic [3:0]       dig_h, dig_t, dig_o, digit;
    logic [1:0]       ndig;
    logic [7:0]       tx_byte_nx;
    logic             xfer, last_col, last_row;

    function automatic logic [DIM_W-1:0] clip_dim(input logic [DIM_W-1:0] d);
        return (d > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : d;
    endfunction

    bin2dec_digits #(.ELEM_W(ELEM_W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .value (rd_data),
        .done  (conv_done),
        .dig_h (dig_h),
        .dig_t (dig_t),
        .dig_o (dig_o),
        .ndig  (ndig)
    );

    assign xfer     = tx_valid && tx_ready;
    assign last_col = (c_q + DIM_W'(1)) >= cols_q;
    assign last_row = (r_q + DIM_W'(1)) == rows_q;
    assign rd_addr  = ADDR_W'(r_q) * ADDR_W'(MAX_DIM) + ADDR_W'(c_q);
    assign new_line = tx_valid && (tx_data == ASCII_LF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nx;
    end

    // Emit states move on only when the current byte is taken.
    always_comb begin
        state_nx   = state_q;
        dig_idx_nx = dig_idx_q;
        case (state_q)
            S_IDLE:  if (start) state_nx = (rows == '0 || cols == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nx = S_WAIT;
            S_WAIT:  state_nx = S_CONV;
            S_CONV: if (conv_done) begin
                state_nx   = S_EMIT_DIG;
                dig_idx_nx = 2'd3 - ndig;
            end
            S_EMIT_DIG: if (xfer) begin
                if (dig_idx_q != 2'd2)  dig_idx_nx = dig_idx_q + 2'd1;
                else if (!last_col)     state_nx = S_EMIT_SEP;
                else if (CRLF != 0)     state_nx = S_EMIT_CR;
                else                    state_nx = S_EMIT_LF;
            end
            S_EMIT_SEP: if (xfer) state_nx = S_FETCH;
            S_EMIT_CR:  if (xfer) state_nx = S_EMIT_LF;
            S_EMIT_LF:  if (xfer) state_nx = last_row ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en      = (state_q == S_FETCH);
        conv_start = (state_q == S_WAIT);
        busy       = (state_q != S_IDLE) && (state_q != S_DONE);
        done       = (state_q == S_DONE);
        case (dig_idx_nx)
            2'd0:    digit = dig_h;
            2'd1:    digit = dig_t;
            default: digit = dig_o;
        endcase
        case (state_nx)
            S_EMIT_DIG: tx_byte_nx = ASCII_ZERO + {4'd0, digit};
            S_EMIT_SEP: tx_byte_nx = ASCII_SPACE;
            S_EMIT_CR:  tx_byte_nx = ASCII_CR;
            S_EMIT_LF:  tx_byte_nx = ASCII_LF;
            default:    tx_byte_nx = 8'd0;
        endcase
    end

    // tx regs load from the next state, so a stall simply reloads the same byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q    <= '0;
            cols_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            dig_idx_q <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
        end else begin
            dig_idx_q <= dig_idx_nx;
            tx_valid  <= is_emit(state_nx);
            tx_data   <= tx_byte_nx;
            if (state_q == S_IDLE && start) begin
                rows_q <= clip_dim(rows);
                cols_q <= clip_dim(cols);
                r_q    <= '0;
                c_q    <= '0;
            end
            if (xfer && state_q == S_EMIT_SEP) c_q <= c_q + DIM_W'(1);
            if (xfer && state_q == S_EMIT_LF) begin
                c_q <= '0;
                r_q <= r_q + DIM_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_ascii_formatter.sv
// Directed bench: LF-terminated instance (a) and CR LF instance (b) share one matrix store.
module tb_matrix_ascii_formatter;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int DIM_W   = 3;
    localparam int ADDR_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start_a = 1'b0, start_b = 1'b0;
    logic [DIM_W-1:0]  rows_a = '0, cols_a = '0, rows_b = '0, cols_b = '0;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
    logic              rd_en_a, rd_en_b;
    logic [ELEM_W-1:0] rd_data_a = '0, rd_data_b = '0;
    logic [7:0]        tx_data_a, tx_data_b;
    logic              tx_valid_a, tx_valid_b;
    logic              tx_ready_a = 1'b1, tx_ready_b = 1'b1;
    logic              new_line_a, new_line_b, busy_a, busy_b, done_a, done_b;

    matrix_ascii_formatter #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W),
                             .ADDR_W(ADDR_W), .CRLF(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rows(rows_a), .cols(cols_a),
        .rd_addr(rd_addr_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .new_line(new_line_a), .busy(busy_a), .done(done_a)
    );

    matrix_ascii_formatter #(.ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .DIM_W(DIM_W),
                             .ADDR_W(ADDR_W), .CRLF(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rows(rows_b), .cols(cols_b),
        .rd_addr(rd_addr_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .new_line(new_line_b), .busy(busy_b), .done(done_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Matrix store: data one cycle after rd_en, garbage otherwise.
    logic [ELEM_W-1:0] mem [0:MAX_DIM*MAX_DIM-1];
    always @(posedge clk) begin
        rd_data_a <= rd_en_a ? mem[rd_addr_a] : ELEM_W'($urandom);
        rd_data_b <= rd_en_b ? mem[rd_addr_b] : ELEM_W'($urandom);
    end

    logic [7:0] q_a[$], q_b[$];
    bit         nl_a[$], nl_b[$];
    int         done_a_cnt = 0, done_b_cnt = 0, tv_a_cnt = 0;
    bit         stall_a = 1'b0;
    logic [7:0] stall_d = 8'd0;

    always @(negedge clk) begin
        if (stall_a) chk("stall_hold", 64'({tx_valid_a, tx_data_a}), 64'({1'b1, stall_d}));
        stall_a = tx_valid_a && !tx_ready_a && !rst;
        stall_d = tx_data_a;
        if (tx_valid_a) tv_a_cnt++;
        if (tx_valid_a && tx_ready_a) begin
            q_a.push_back(tx_data_a);
            nl_a.push_back(new_line_a);
        end
        if (tx_valid_b && tx_ready_b) begin
            q_b.push_back(tx_data_b);
            nl_b.push_back(new_line_b);
        end
        if (done_a) done_a_cnt++;
        if (done_b) done_b_cnt++;
    end

    // Sink ready: always 1, or 1,0,0,1 then random stalls.
    int rdy_mode = 0;
    int rdy_cyc  = 0;
    initial forever begin
        @(posedge clk); #1;
        rdy_cyc++;
        if (rdy_mode == 0)   tx_ready_a = 1'b1;
        else if (rdy_cyc == 1 || rdy_cyc == 4) tx_ready_a = 1'b1;
        else if (rdy_cyc < 4) tx_ready_a = 1'b0;
        else                  tx_ready_a = 1'($urandom_range(0, 1));
    end

    task automatic clr();
        q_a.delete(); nl_a.delete(); q_b.delete(); nl_b.delete();
        done_a_cnt = 0; done_b_cnt = 0; tv_a_cnt = 0;
    endtask

    task automatic go(input bit sel, input int r, input int c);
        @(posedge clk); #1;
        if (sel) begin rows_b = DIM_W'(r); cols_b = DIM_W'(c); start_b = 1'b1; end
        else     begin rows_a = DIM_W'(r); cols_a = DIM_W'(c); start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int n = 0;
        while ((sel ? done_b_cnt : done_a_cnt) == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? done_b_cnt : done_a_cnt) == 0) chk("timeout_done", 64'(0), 64'(1));
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bytes(input int cnt, input int budget);
        int n = 0;
        while (q_a.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() < cnt) chk("timeout_bytes", 64'(q_a.size()), 64'(cnt));
    endtask

    task automatic cmp_stream(input string tag, input bit sel, input string exp);
        int         n;
        logic [7:0] b;
        bit         nl;
        n = sel ? q_b.size() : q_a.size();
        chk($sformatf("%s_len", tag), 64'(n), 64'(exp.len()));
        for (int i = 0; i < exp.len() && i < n; i++) begin
            b  = sel ? q_b[i] : q_a[i];
            nl = sel ? nl_b[i] : nl_a[i];
            chk($sformatf("%s_byte%0d", tag, i), 64'(b), 64'(exp[i]));
            chk($sformatf("%s_nl%0d", tag, i), 64'(nl), 64'(exp[i] == 8'd10));
        end
    endtask

    task automatic load_2x3();
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
        mem[5] = 8'd4; mem[6] = 8'd5; mem[7] = 8'd6;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_rst;
        for (int i = 0; i < MAX_DIM*MAX_DIM; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", 64'(tx_valid_a), 64'(0));
        chk("rst_tx_data",  64'(tx_data_a),  64'(0));
        chk("rst_busy",     64'(busy_a),     64'(0));
        chk("rst_done",     64'(done_a),     64'(0));
        chk("rst_rd_en",    64'(rd_en_a),    64'(0));
        chk("rst_new_line", 64'(new_line_a), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // 2x3 with an always-ready sink
        load_2x3();
        clr();
        go(0, 2, 3);
        @(negedge clk);
        chk("t1_busy", 64'(busy_a), 64'(1));
        wait_done(0, 2000);
        cmp_stream("t1", 0, "1 2 3\n4 5 6\n");
        chk("t1_done_cnt", 64'(done_a_cnt), 64'(1));
        chk("t1_idle", 64'(busy_a), 64'(0));

        // zero, single digit, two digits, max value
        mem[0] = 8'd0; mem[1] = 8'd7; mem[2] = 8'd10; mem[3] = 8'd255;
        clr();
        go(0, 1, 4);
        wait_done(0, 2000);
        cmp_stream("t2", 0, "0 7 10 255\n");

        // same 2x3 with sink stalls
        load_2x3();
        clr();
        rdy_mode = 1;
        rdy_cyc  = 0;
        go(0, 2, 3);
        wait_done(0, 4000);
        rdy_mode = 0;
        cmp_stream("t3", 0, "1 2 3\n4 5 6\n");
        chk("t3_done_cnt", 64'(done_a_cnt), 64'(1));

        // zero rows: immediate done, no bytes
        clr();
        go(0, 0, 3);
        @(negedge clk);
        chk("t4_done", 64'(done_a), 64'(1));
        chk("t4_busy", 64'(busy_a), 64'(0));
        repeat (8) @(negedge clk);
        chk("t4_tv_cycles", 64'(tv_a_cnt), 64'(0));
        chk("t4_done_cnt",  64'(done_a_cnt), 64'(1));

        // start during an active 2x2 print is ignored
        clr();
        go(0, 2, 2);
        wait_bytes(2, 500);
        go(0, 1, 1);
        wait_done(0, 2000);
        cmp_stream("t5", 0, "1 2\n4 5\n");
        chk("t5_done_cnt", 64'(done_a_cnt), 64'(1));

        // column clip 7 -> 5
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd42; mem[4] = 8'd100;
        clr();
        go(0, 1, 7);
        wait_done(0, 3000);
        cmp_stream("t6", 0, "1 2 3 42 100\n");

        // row clip 7 -> 5
        mem[5] = 8'd4; mem[10] = 8'd0; mem[15] = 8'd99; mem[20] = 8'd200;
        clr();
        go(0, 7, 1);
        wait_done(0, 3000);
        cmp_stream("t7", 0, "1\n4\n0\n99\n200\n");

        // CR LF instance
        mem[0] = 8'd9; mem[1] = 8'd8;
        clr();
        go(1, 1, 2);
        wait_done(1, 2000);
        cmp_stream("t8", 1, "9 8\015\012");
        chk("t8_done_cnt", 64'(done_b_cnt), 64'(1));

        // reset partway through the second row
        load_2x3();
        clr();
        go(0, 2, 3);
        wait_bytes(7, 2000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t9_rst_tx_valid", 64'(tx_valid_a), 64'(0));
        chk("t9_rst_busy",     64'(busy_a),     64'(0));
        chk("t9_rst_done",     64'(done_a),     64'(0));
        n_rst = q_a.size();
        repeat (4) @(negedge clk);
        chk("t9_no_more_bytes", 64'(q_a.size()), 64'(n_rst));
        chk("t9_no_done",       64'(done_a_cnt), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        clr();
        go(0, 2, 3);
        wait_done(0, 2000);
        cmp_stream("t9", 0, "1 2 3\n4 5 6\n");
        chk("t9_done_cnt", 64'(done_a_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
